// File: rtl/axis_pkt_checker.sv
// AXI-stream packet checker sink.
// Consumes reassembled packets from the buffer read side, applies optional
// LFSR-driven backpressure between packets, validates every beat against the
// packet word format and tracks per-flow packet-id ordering.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   s_tdata_i          stream data (only bits [31:0] are checked)
//   s_tvalid_i         data valid
//   s_tready_o         sink ready (registered)
//   s_tlast_i          last beat of packet
//   bp_en_i            1 = randomised backpressure, 0 = ready held high
//   pkt_done_o         one-cycle pulse after the tlast beat is accepted
//   pkt_ok_o           completed packet had no error
//   pkt_id_o           id field from word 0 of the completed packet
//   pkt_flow_o         flow field from word 0 of the completed packet
//   err_code_o         first error of the completed packet (0 = none)
//   good_cnt_o         saturating good packet count
//   bad_cnt_o          saturating bad packet count
//   err_sticky_o       bit k set once any packet reports code k
module axis_pkt_checker #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FLOWS_W   = 3,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  input  logic              s_tlast_i,
  input  logic              bp_en_i,
  output logic              pkt_done_o,
  output logic              pkt_ok_o,
  output logic [7:0]        pkt_id_o,
  output logic [3:0]        pkt_flow_o,
  output logic [2:0]        err_code_o,
  output logic [CNT_W-1:0]  good_cnt_o,
  output logic [CNT_W-1:0]  bad_cnt_o,
  output logic [7:0]        err_sticky_o
);

  localparam int unsigned NumFlows = 2 ** FLOWS_W;

  typedef enum logic [1:0] {StW0, StW1, StPay, StDrain} state_e;

  state_e                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [3:0]                   flow_q;
  logic [7:0]                   len_q, id_q, beat_q;
  logic [2:0]                   cur_err_q;
  logic [NumFlows-1:0]          seen_q;
  logic [NumFlows-1:0][7:0]     last_id_q;
  logic                         done_q, ok_q;
  logic [7:0]                   pkt_id_q;
  logic [3:0]                   pkt_flow_q;
  logic [2:0]                   err_code_q;
  logic [CNT_W-1:0]             good_q, bad_q;
  logic [7:0]                   sticky_q;

  // Beat field decode
  logic [3:0]         tag_w, flow_w;
  logic [7:0]         len_w, id_w, byte0_w;
  logic               accept, flow_ok, order_ok, fields_match, at_last, early_last;
  logic [FLOWS_W-1:0] flow_idx;
  logic [7:0]         id_diff, last_idx;
  logic [2:0]         beat_err, pkt_err;
  logic [7:0]         fin_id;
  logic [3:0]         fin_flow;

  assign tag_w   = s_tdata_i[31:28];
  assign flow_w  = s_tdata_i[27:24];
  assign len_w   = s_tdata_i[23:16];
  assign id_w    = s_tdata_i[15:8];
  assign byte0_w = s_tdata_i[7:0];

  assign accept   = s_tvalid_i & ready_q;
  assign flow_ok  = (32'(flow_w) < NumFlows);
  assign flow_idx = FLOWS_W'(flow_w);
  // Id must advance by 1..127 modulo 256 relative to the flow's previous id
  assign id_diff  = id_w - last_id_q[flow_idx];
  assign order_ok = (id_diff != 8'd0) && !id_diff[7];

  assign fields_match = (flow_w == flow_q) && (len_w == len_q) && (id_w == id_q);
  assign last_idx     = len_q - 8'd1;
  assign at_last      = (beat_q == last_idx);
  assign early_last   = s_tlast_i && (beat_q < last_idx);

  always_comb begin
    beat_err = 3'd0;
    state_d  = state_q;
    unique case (state_q)
      StW0: begin
        if (tag_w != 4'h8)                               beat_err = 3'd1;
        else if ((byte0_w != id_w) || !flow_ok)          beat_err = 3'd2;
        else if (len_w < 8'd2)                           beat_err = 3'd7;
        else if (seen_q[flow_idx] && !order_ok)          beat_err = 3'd6;
        else if (s_tlast_i)                              beat_err = 3'd4;
        state_d = StW1;
      end
      StW1: begin
        if (tag_w != 4'h4)                                        beat_err = 3'd1;
        else if (!fields_match || (byte0_w != {4'h0, flow_q}))    beat_err = 3'd2;
        else if (early_last)                                      beat_err = 3'd4;
        else if (at_last && !s_tlast_i)                           beat_err = 3'd5;
        state_d = (at_last && !s_tlast_i) ? StDrain : StPay;
      end
      StPay: begin
        if (tag_w != 4'h2)                 beat_err = 3'd1;
        else if (!fields_match)            beat_err = 3'd2;
        else if (byte0_w != beat_q)        beat_err = 3'd3;
        else if (early_last)               beat_err = 3'd4;
        else if (at_last && !s_tlast_i)    beat_err = 3'd5;
        state_d = (at_last && !s_tlast_i) ? StDrain : StPay;
      end
      StDrain: begin
        state_d = StDrain;
      end
    endcase
    if (s_tlast_i) state_d = StW0;
  end

  // First error of the packet wins; cur_err_q is cleared at every packet end
  assign pkt_err  = (cur_err_q != 3'd0) ? cur_err_q : beat_err;
  assign fin_id   = (state_q == StW0) ? id_w : id_q;
  assign fin_flow = (state_q == StW0) ? flow_w : flow_q;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Ready may only drop at a packet boundary, so it is re-drawn only when
  // already low or when the closing beat is taken.
  always_comb begin
    ready_d = 1'b1;
    if (bp_en_i && (!ready_q || (accept && s_tlast_i))) ready_d = lfsr_q[0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StW0;
      ready_q    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      flow_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      beat_q     <= '0;
      cur_err_q  <= '0;
      seen_q     <= '0;
      last_id_q  <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      pkt_id_q   <= '0;
      pkt_flow_q <= '0;
      err_code_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      sticky_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
      done_q  <= accept & s_tlast_i;
      if (accept) begin
        state_q <= state_d;
        if (s_tlast_i)              beat_q <= '0;
        else if (beat_q != 8'hff)   beat_q <= beat_q + 8'd1;
        if (state_q == StW0) begin
          flow_q <= flow_w;
          len_q  <= len_w;
          id_q   <= id_w;
          if (flow_ok) begin
            last_id_q[flow_idx] <= id_w;
            seen_q[flow_idx]    <= 1'b1;
          end
        end
        if (s_tlast_i) begin
          cur_err_q  <= '0;
          ok_q       <= (pkt_err == 3'd0);
          err_code_q <= pkt_err;
          pkt_id_q   <= fin_id;
          pkt_flow_q <= fin_flow;
          if (pkt_err == 3'd0) begin
            if (good_q != '1) good_q <= good_q + 1'b1;
          end else begin
            if (bad_q != '1) bad_q <= bad_q + 1'b1;
            sticky_q[pkt_err] <= 1'b1;
          end
        end else begin
          cur_err_q <= pkt_err;
        end
      end
    end
  end

  assign s_tready_o   = ready_q;
  assign pkt_done_o   = done_q;
  assign pkt_ok_o     = ok_q;
  assign pkt_id_o     = pkt_id_q;
  assign pkt_flow_o   = pkt_flow_q;
  assign err_code_o   = err_code_q;
  assign good_cnt_o   = good_q;
  assign bad_cnt_o    = bad_q;
  assign err_sticky_o = sticky_q;

endmodule
